// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, control encodings and the ALU-select helper
// used by the ID stage.
package riscv_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   localparam logic [1:0] SRCA_RD1  = 2'b00;
   localparam logic [1:0] SRCA_PC   = 2'b01;
   localparam logic [1:0] SRCA_ZERO = 2'b10;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_type_e;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       jump;
      logic       jalr;
      logic       branch;
      logic [1:0] alu_src_a;
      logic       alu_src_b;
      logic [3:0] alu_control;
      logic [2:0] funct3;
      logic       illegal;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } ctrl_t;

   // funct7[5] selects sub only for register-register ops; for shifts-right
   // it selects the arithmetic form in both R and I encodings.
   function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                             input logic       f7b5,
                                             input logic       is_reg);
      logic [3:0] sel;
      case (f3)
         3'b000:  sel = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  sel = ALU_SLL;
         3'b010:  sel = ALU_SLT;
         3'b011:  sel = ALU_SLTU;
         3'b100:  sel = ALU_XOR;
         3'b101:  sel = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  sel = ALU_OR;
         default: sel = ALU_AND;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file: two combinational read ports with write-through
// bypass, one write port, x0 hardwired to zero, asynchronous clear.
module register_file
   import riscv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   raddr1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);

   // x0 has no storage; index 0 is never addressed in the array.
   logic [XLEN-1:0] regs_q [1:NREGS-1];
   logic [XLEN-1:0] regs_d [1:NREGS-1];
   logic            wr_en;

   assign wr_en = we && (waddr != '0);

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rdata1 = '0;
      if (raddr1 != '0) begin
         rdata1 = (wr_en && waddr == raddr1) ? wdata : regs_q[raddr1];
      end
   end

   always_comb begin
      rdata2 = '0;
      if (raddr2 != '0) begin
         rdata2 = (wr_en && waddr == raddr2) ? wdata : regs_q[raddr2];
      end
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: register file read, control decode, immediate generation
// and the ID/EX pipeline register with flush.
module decode_stage
   import riscv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            FlushE,
   input  logic [31:0]     InstrD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            RegWriteW,
   input  logic [4:0]      RdW,
   input  logic [XLEN-1:0] ResultW,
   output logic [4:0]      Rs1D,
   output logic [4:0]      Rs2D,
   output logic            RegWriteE,
   output logic [1:0]      ResultSrcE,
   output logic            MemWriteE,
   output logic            JumpE,
   output logic            JalrE,
   output logic            BranchE,
   output logic [1:0]      ALUSrcAE,
   output logic            ALUSrcBE,
   output logic [3:0]      ALUControlE,
   output logic [2:0]      Funct3E,
   output logic            IllegalE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [4:0]      RdE
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            f7b5;
   imm_type_e       imm_type;
   ctrl_t           ctrl_d, ctrl_q;
   logic [XLEN-1:0] rd1_d, rd1_q;
   logic [XLEN-1:0] rd2_d, rd2_q;
   logic [XLEN-1:0] imm_d, imm_q;
   logic [XLEN-1:0] pc_q, pc4_q;

   assign opcode = InstrD[6:0];
   assign funct3 = InstrD[14:12];
   assign f7b5   = InstrD[30];
   assign Rs1D   = InstrD[19:15];
   assign Rs2D   = InstrD[24:20];

   register_file #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (5)
   ) u_regfile (
      .clk    (CLK),
      .rst    (RST),
      .we     (RegWriteW),
      .waddr  (RdW),
      .wdata  (ResultW),
      .raddr1 (Rs1D),
      .raddr2 (Rs2D),
      .rdata1 (rd1_d),
      .rdata2 (rd2_d)
   );

   always_comb begin
      ctrl_d        = '0;
      ctrl_d.funct3 = funct3;
      ctrl_d.rs1    = Rs1D;
      ctrl_d.rs2    = Rs2D;
      ctrl_d.rd     = InstrD[11:7];
      imm_type      = IMM_NONE;
      case (opcode)
         OP_LOAD: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.result_src = RES_MEM;
            ctrl_d.alu_src_b  = 1'b1;
            imm_type          = IMM_I;
         end
         OP_STORE: begin
            ctrl_d.mem_write = 1'b1;
            ctrl_d.alu_src_b = 1'b1;
            imm_type         = IMM_S;
         end
         OP_REG: begin
            ctrl_d.reg_write   = 1'b1;
            ctrl_d.alu_control = alu_decode(funct3, f7b5, 1'b1);
         end
         OP_IMM: begin
            ctrl_d.reg_write   = 1'b1;
            ctrl_d.alu_src_b   = 1'b1;
            ctrl_d.alu_control = alu_decode(funct3, f7b5, 1'b0);
            imm_type           = IMM_I;
         end
         OP_BRANCH: begin
            ctrl_d.branch      = 1'b1;
            ctrl_d.alu_control = ALU_SUB;
            imm_type           = IMM_B;
         end
         OP_JAL: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.jump       = 1'b1;
            ctrl_d.result_src = RES_PC4;
            imm_type          = IMM_J;
         end
         OP_JALR: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.jalr       = 1'b1;
            ctrl_d.result_src = RES_PC4;
            ctrl_d.alu_src_b  = 1'b1;
            imm_type          = IMM_I;
         end
         OP_LUI: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_src_a = SRCA_ZERO;
            ctrl_d.alu_src_b = 1'b1;
            imm_type         = IMM_U;
         end
         OP_AUIPC: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_src_a = SRCA_PC;
            ctrl_d.alu_src_b = 1'b1;
            imm_type         = IMM_U;
         end
         default: begin
            // An all-zero word is a flushed IF/ID slot, not a real fault.
            ctrl_d.funct3  = '0;
            ctrl_d.illegal = (InstrD != '0);
         end
      endcase
   end

   always_comb begin
      imm_d = '0;
      case (imm_type)
         IMM_I:   imm_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
         IMM_S:   imm_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         IMM_B:   imm_d = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                           InstrD[30:25], InstrD[11:8], 1'b0};
         IMM_U:   imm_d = {{(XLEN-32){InstrD[31]}}, InstrD[31:12], 12'b0};
         IMM_J:   imm_d = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12],
                           InstrD[20], InstrD[30:21], 1'b0};
         default: imm_d = '0;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST || FlushE) begin
         ctrl_q <= '0;
         rd1_q  <= '0;
         rd2_q  <= '0;
         imm_q  <= '0;
         pc_q   <= '0;
         pc4_q  <= '0;
      end else begin
         ctrl_q <= ctrl_d;
         rd1_q  <= rd1_d;
         rd2_q  <= rd2_d;
         imm_q  <= imm_d;
         pc_q   <= PCD;
         pc4_q  <= PCPlus4D;
      end
   end

   assign RegWriteE   = ctrl_q.reg_write;
   assign ResultSrcE  = ctrl_q.result_src;
   assign MemWriteE   = ctrl_q.mem_write;
   assign JumpE       = ctrl_q.jump;
   assign JalrE       = ctrl_q.jalr;
   assign BranchE     = ctrl_q.branch;
   assign ALUSrcAE    = ctrl_q.alu_src_a;
   assign ALUSrcBE    = ctrl_q.alu_src_b;
   assign ALUControlE = ctrl_q.alu_control;
   assign Funct3E     = ctrl_q.funct3;
   assign IllegalE    = ctrl_q.illegal;
   assign Rs1E        = ctrl_q.rs1;
   assign Rs2E        = ctrl_q.rs2;
   assign RdE         = ctrl_q.rd;
   assign RD1E        = rd1_q;
   assign RD2E        = rd2_q;
   assign ImmExtE     = imm_q;
   assign PCE         = pc_q;
   assign PCPlus4E    = pc4_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-encoded RV32I words with expected
// control/immediate/operand values checked one edge later.
module tb_decode_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic        FlushE;
   logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
   logic        RegWriteW;
   logic [4:0]  RdW;
   logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
   logic        RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcBE, IllegalE;
   logic [1:0]  ResultSrcE, ALUSrcAE;
   logic [3:0]  ALUControlE;
   logic [2:0]  Funct3E;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   decode_stage dut (
      .CLK(CLK), .RST(RST), .FlushE(FlushE), .InstrD(InstrD), .PCD(PCD),
      .PCPlus4D(PCPlus4D), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
      .MemWriteE(MemWriteE), .JumpE(JumpE), .JalrE(JalrE), .BranchE(BranchE),
      .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .ALUControlE(ALUControlE),
      .Funct3E(Funct3E), .IllegalE(IllegalE), .RD1E(RD1E), .RD2E(RD2E),
      .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E),
      .Rs2E(Rs2E), .RdE(RdE)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input string name, input logic [31:0] instr);
      InstrD = instr;
      tick();
      $display("step %-10s instr=%h RD1E=%h RD2E=%h ImmExtE=%h ALU=%b",
               name, instr, RD1E, RD2E, ImmExtE, ALUControlE);
   endtask

   initial begin
      RST = 1'b1; FlushE = 1'b0; InstrD = '0; PCD = '0; PCPlus4D = '0;
      RegWriteW = 1'b0; RdW = '0; ResultW = '0;
      tick(); tick();
      check("rst_regwrite", 32'(RegWriteE), 32'd0);
      check("rst_rd1", RD1E, 32'd0);
      RST = 1'b0;

      // Writeback x5, then read it back through add x6,x5,x0
      RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEADBEEF;
      step("wb_x5", 32'h0);
      RegWriteW = 1'b0;
      InstrD = 32'h00028333; PCD = 32'h100; PCPlus4D = 32'h104;
      #1;
      check("rs1d_comb", 32'(Rs1D), 32'd5);
      step("add", 32'h00028333);
      check("add_rd1", RD1E, 32'hDEADBEEF);
      check("add_rd", 32'(RdE), 32'd6);
      check("add_rs1e", 32'(Rs1E), 32'd5);
      check("add_alu", 32'(ALUControlE), 32'd0);
      check("add_regwrite", 32'(RegWriteE), 32'd1);
      check("add_pc", PCE, 32'h100);
      check("add_pc4", PCPlus4E, 32'h104);

      // Same-cycle bypass on rs1 (x7), then confirm the write landed
      RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'h12345678;
      step("byp_x7", 32'h00038433);
      check("byp_rd1", RD1E, 32'h12345678);
      RegWriteW = 1'b0;
      step("rd_x7", 32'h00038433);
      check("stored_rd1", RD1E, 32'h12345678);
      RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'hCAFEBABE;
      step("byp_x0", 32'h00000433);
      check("byp_x0_rd1", RD1E, 32'd0);
      RdW = 5'd9; ResultW = 32'h0BADF00D;
      step("byp_rs2", 32'h00900433);
      check("byp_rd2", RD2E, 32'h0BADF00D);
      RegWriteW = 1'b0;

      step("sw", 32'hFE20AE23);
      check("sw_imm", ImmExtE, 32'hFFFFFFFC);
      check("sw_memwrite", 32'(MemWriteE), 32'd1);
      check("sw_regwrite", 32'(RegWriteE), 32'd0);
      check("sw_srcb", 32'(ALUSrcBE), 32'd1);

      step("beq", 32'hFE000CE3);
      check("beq_imm", ImmExtE, 32'hFFFFFFF8);
      check("beq_branch", 32'(BranchE), 32'd1);
      check("beq_alu", 32'(ALUControlE), 32'd1);

      step("lui", 32'hABCDE1B7);
      check("lui_imm", ImmExtE, 32'hABCDE000);
      check("lui_srca", 32'(ALUSrcAE), 32'd2);
      check("lui_rd", 32'(RdE), 32'd3);

      step("jal", 32'h010000EF);
      check("jal_jump", 32'(JumpE), 32'd1);
      check("jal_ressrc", 32'(ResultSrcE), 32'd2);
      check("jal_imm", ImmExtE, 32'd16);

      step("jalr", 32'h00008067);
      check("jalr_jalr", 32'(JalrE), 32'd1);
      check("jalr_regwrite", 32'(RegWriteE), 32'd1);
      check("jalr_rd", 32'(RdE), 32'd0);

      step("addi1024", 32'h40000093);
      check("addi_alu", 32'(ALUControlE), 32'd0);
      check("addi_imm", ImmExtE, 32'h00000400);
      step("srai", 32'h4030D093);
      check("srai_alu", 32'(ALUControlE), 32'd7);
      step("sub", 32'h403100B3);
      check("sub_alu", 32'(ALUControlE), 32'd1);

      FlushE = 1'b1;
      step("flush_sw", 32'hFE20AE23);
      FlushE = 1'b0;
      check("flush_memwrite", 32'(MemWriteE), 32'd0);
      check("flush_imm", ImmExtE, 32'd0);
      check("flush_pc", PCE, 32'd0);
      check("flush_rs2", 32'(Rs2E), 32'd0);

      step("illegal", 32'hFFFFFFFF);
      check("ill_flag", 32'(IllegalE), 32'd1);
      check("ill_regwrite", 32'(RegWriteE), 32'd0);
      check("ill_memwrite", 32'(MemWriteE), 32'd0);
      step("zero", 32'h0);
      check("zero_illegal", 32'(IllegalE), 32'd0);

      // Mid-cycle async reset with live outputs and x5 still holding data
      step("lui2", 32'hABCDE1B7);
      #2 RST = 1'b1;
      #1;
      check("arst_imm", ImmExtE, 32'd0);
      check("arst_regwrite", 32'(RegWriteE), 32'd0);
      check("arst_srca", 32'(ALUSrcAE), 32'd0);
      tick();
      RST = 1'b0;
      step("post_rst", 32'h00028333);
      check("post_rst_rd1", RD1E, 32'd0);
      check("post_rst_regwrite", 32'(RegWriteE), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 5-stage RV32I pipeline; consumes InstrD/PCD/PCPlus4D from the fetch stage's IF/ID register.
- Contains:
  - the 32x32 register file (written back from the W stage)
  - the main/ALU control decoder
  - the immediate generator
  - the ID/EX pipeline register feeding the execute stage.
- Exposes Rs1D/Rs2D for the hazard unit. Consumes FlushE from the hazard unit.

Parameters:
XLEN, 32, datapath width
NREGS, 32, architectural registers (x0 hardwired zero)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
FlushE  in  1  load bubble into ID/EX
InstrD  in  32  instruction from IF/ID
PCD  in  32  PC of InstrD
PCPlus4D  in  32  PCD+4
RegWriteW  in  1  writeback enable
RdW  in  5  writeback destination
ResultW  in  32  writeback data
Rs1D  out  5  InstrD[19:15], combinational
Rs2D  out  5  InstrD[24:20], combinational
RegWriteE  out  1  registered control
ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
MemWriteE  out  1  store
JumpE  out  1  jal
JalrE  out  1  jalr
BranchE  out  1  conditional branch
ALUSrcAE  out  2  00 RD1, 01 PC, 10 zero
ALUSrcBE  out  1  0 RD2, 1 ImmExt
ALUControlE  out  4  ALU opcode
Funct3E  out  3  branch/load/store qualifier
IllegalE  out  1  unsupported opcode flag
RD1E, RD2E  out  32  register operands
ImmExtE  out  32  sign-extended immediate
PCE, PCPlus4E  out  32  passed-through PC values
Rs1E, Rs2E, RdE  out  5  register indices for forwarding

Behaviour:
- Reset: RST high asynchronously clears all ID/EX outputs and all 32 registers to 0. Registers stay 0 while RST is held.
- Register file:
  - Write on rising CLK when RegWriteW=1 and RdW!=0. Writes to x0 are ignored.
  - Reads are combinational with write-through bypass: if RegWriteW=1, RdW!=0 and RdW==Rs1D (or Rs2D), the read returns ResultW in the same cycle. Reads of x0 always return 0.
- Decode (combinational on InstrD[6:0]):
  - lw 0000011: RegWrite, ResultSrc=01, ALUSrcB=1, I-imm, add
  - sw 0100011: MemWrite, ALUSrcB=1, S-imm, add
  - R 0110011: RegWrite, ALU from funct3/funct7[5]
  - I-ALU 0010011: RegWrite, ALUSrcB=1, I-imm. funct7[5] is honoured only for srai.
  - branch 1100011: Branch, B-imm, sub
  - jal 1101111: RegWrite, Jump, ResultSrc=10, J-imm
  - jalr 1100111: RegWrite, Jalr, ResultSrc=10, ALUSrcB=1, I-imm, add
  - lui 0110111: RegWrite, ALUSrcA=10, ALUSrcB=1, U-imm, add
  - auipc 0010111: RegWrite, ALUSrcA=01, ALUSrcB=1, U-imm, add
  - Any other opcode: all controls 0 and IllegalE=1 next cycle. InstrD=0 (a flushed IF/ID) decodes as illegal-silent: all controls 0 and IllegalE=0.
- ALUControl encoding:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor
  - 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu
- Immediates: sign-extended from bit 31. The U-imm low 12 bits are 0. B-imm and J-imm bit 0 is 0.
- ID/EX register:
  - Latency 1 cycle. Captures every rising CLK; there is no stall input.
  - FlushE=1 at an edge loads all outputs to 0, i.e. a bubble with RegWriteE=MemWriteE=JumpE=JalrE=BranchE=0.
  - FlushE takes priority over capture. RST takes priority over both.
- Simultaneous writeback and read of the same register: bypassed value is captured in ID/EX (no stale read).
- RST deasserting mid-stream: the first edge after deassert captures the current InstrD normally.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants
  - ALUControl codes
  - ResultSrc and ALUSrcA codes
  - immediate-type enum
- One sub-module register_file (2 read ports, 1 write port, bypass, async clear).
- Control decoder and immediate generator stay inline as combinational blocks.

Test Plan:
- Reset: assert RST mid-cycle -> all E outputs 0 immediately. After release, reading x5 returns 0.
- Writeback then read: RegWriteW=1, RdW=5, ResultW=0xDEADBEEF at edge 1. InstrD=add x6,x5,x0 (0x00028333) at edge 2 -> RD1E=0xDEADBEEF, RdE=6, ALUControlE=0000, RegWriteE=1.
- Bypass: same cycle RegWriteW=1, RdW=7, ResultW=0x12345678 and InstrD reads rs1=x7 -> RD1E=0x12345678 after one edge. Repeat with RdW=0 -> RD1E=0.
- Immediates:
  - sw x2,-4(x1) (0xFE20AE23) -> ImmExtE=0xFFFFFFFC, MemWriteE=1, RegWriteE=0
  - beq x0,x0,-8 (0xFE000CE3) -> ImmExtE=0xFFFFFFF8, BranchE=1, ALUControlE=0001
  - lui x3,0xABCDE (0xABCDE1B7) -> ImmExtE=0xABCDE000, ALUSrcAE=10
- Jumps: jal x1,+16 (0x010000EF) -> JumpE=1, ResultSrcE=10, ImmExtE=16. jalr x0,0(x1) (0x00008067) -> JalrE=1, RegWriteE=1, RdE=0.
- Flush/illegal:
  - FlushE=1 with a valid sw in InstrD -> all E outputs 0.
  - InstrD=0xFFFFFFFF -> IllegalE=1, all controls 0.
  - InstrD=0 -> IllegalE=0.
